// File: rtl/tile_game_sequencer_pkg.sv
// Shared types and lane constants for the falling-tile game controller and pattern generator.
package tile_game_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StPlay,
        StRoundDone,
        StGameOver
    } state_t;

    localparam logic [2:0] NOTE_L = 3'b100;
    localparam logic [2:0] NOTE_M = 3'b010;
    localparam logic [2:0] NOTE_R = 3'b001;

endpackage

// File: rtl/tile_game_sequencer_row_timer.sv
// Per-row frame counter: counts frame ticks and flags the tick that exhausts the row's time.
module row_timer #(
    parameter int unsigned TIMEOUT_FRAMES = 60
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic tick_i,
    output logic timeout_o
);

    localparam int unsigned CntW = (TIMEOUT_FRAMES > 2) ? $clog2(TIMEOUT_FRAMES) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_FRAMES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (tick_i) begin
            cnt_d = (cnt_q == LastCnt) ? '0 : cnt_q + CntW'(1);
        end
    end

    assign timeout_o = tick_i && (cnt_q == LastCnt);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tile_game_sequencer.sv
// Game-flow FSM: requests patterns, steps the active row, judges key presses and keeps
// score, misses and round count. All outputs come straight from flops.
module tile_game_sequencer
    import tile_game_pkg::*;
#(
    parameter int unsigned NUM_ROWS       = 100,
    parameter int unsigned MAX_ROUNDS     = 4,
    parameter int unsigned TIMEOUT_FRAMES = 60,
    parameter int unsigned MAX_MISSES     = 3,
    parameter int unsigned LOAD_CYCLES    = 2,
    parameter int unsigned SCORE_W        = 16
) (
    input  logic               clk,
    input  logic               Reset,
    input  logic               start_btn,
    input  logic               frame_tick,
    input  logic               key_valid,
    input  logic [2:0]         key_lane,
    input  logic [2:0]         cur_note,
    output logic               regen,
    output logic [6:0]         row_idx,
    output logic [2:0]         round,
    output logic [SCORE_W-1:0] score,
    output logic [1:0]         misses,
    output logic               hit_pulse,
    output logic               miss_pulse,
    output logic               playing,
    output logic               game_over,
    output logic               won
);

    localparam int unsigned LoadW = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;

    state_t             state_q, state_d;
    logic [LoadW-1:0]   load_cnt_q, load_cnt_d;
    logic               start_q;
    logic               regen_q, regen_d;
    logic [6:0]         row_idx_q, row_idx_d;
    logic [2:0]         round_q, round_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [1:0]         misses_q, misses_d;
    logic               hit_q, hit_d;
    logic               miss_q, miss_d;
    logic               playing_q, playing_d;
    logic               game_over_q, game_over_d;
    logic               won_q, won_d;

    logic start_rise, timeout, is_hit, is_miss, timer_clear;

    assign start_rise  = start_btn & ~start_q;
    assign timer_clear = (state_q != StPlay) || key_valid;

    row_timer #(
        .TIMEOUT_FRAMES(TIMEOUT_FRAMES)
    ) u_row_timer (
        .clk_i    (clk),
        .rst_i    (Reset),
        .clear_i  (timer_clear),
        .tick_i   (frame_tick),
        .timeout_o(timeout)
    );

    // A key press always wins over a coincident timeout tick.
    assign is_hit  = key_valid && (key_lane == cur_note);
    assign is_miss = key_valid ? !is_hit : timeout;

    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        regen_d    = 1'b0;
        row_idx_d  = row_idx_q;
        round_d    = round_q;
        score_d    = score_q;
        misses_d   = misses_q;
        hit_d      = 1'b0;
        miss_d     = 1'b0;
        won_d      = won_q;

        unique case (state_q)
            StIdle, StGameOver: begin
                if (start_rise) begin
                    regen_d    = 1'b1;
                    round_d    = 3'd1;
                    score_d    = '0;
                    misses_d   = '0;
                    won_d      = 1'b0;
                    load_cnt_d = '0;
                    state_d    = StLoad;
                end
            end
            StLoad: begin
                if (load_cnt_q == LoadW'(LOAD_CYCLES - 1)) begin
                    row_idx_d = '0;
                    state_d   = StPlay;
                end else begin
                    load_cnt_d = load_cnt_q + LoadW'(1);
                end
            end
            StPlay: begin
                if (is_hit) begin
                    hit_d   = 1'b1;
                    score_d = (score_q == '1) ? score_q : score_q + SCORE_W'(1);
                end
                if (is_miss) begin
                    miss_d   = 1'b1;
                    misses_d = misses_q + 2'd1;
                end
                if (is_hit || is_miss) begin
                    if (row_idx_q == 7'(NUM_ROWS - 1)) begin
                        state_d = StRoundDone;
                    end else begin
                        row_idx_d = row_idx_q + 7'd1;
                    end
                end
                // Losing outranks finishing the last row in the same cycle.
                if (is_miss && (misses_q == 2'(MAX_MISSES - 1))) begin
                    won_d   = 1'b0;
                    state_d = StGameOver;
                end
            end
            StRoundDone: begin
                if (round_q == 3'(MAX_ROUNDS)) begin
                    won_d   = 1'b1;
                    state_d = StGameOver;
                end else if (start_rise) begin
                    round_d    = round_q + 3'd1;
                    regen_d    = 1'b1;
                    load_cnt_d = '0;
                    state_d    = StLoad;
                end
            end
            default: state_d = StIdle;
        endcase

        playing_d   = (state_d == StPlay);
        game_over_d = (state_d == StGameOver);
    end

    always_ff @(posedge clk) begin
        // Tracks the button even in reset so a level held through reset is not an edge.
        start_q <= start_btn;
        if (Reset) begin
            state_q     <= StIdle;
            load_cnt_q  <= '0;
            regen_q     <= 1'b0;
            row_idx_q   <= '0;
            round_q     <= '0;
            score_q     <= '0;
            misses_q    <= '0;
            hit_q       <= 1'b0;
            miss_q      <= 1'b0;
            playing_q   <= 1'b0;
            game_over_q <= 1'b0;
            won_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            load_cnt_q  <= load_cnt_d;
            regen_q     <= regen_d;
            row_idx_q   <= row_idx_d;
            round_q     <= round_d;
            score_q     <= score_d;
            misses_q    <= misses_d;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
            playing_q   <= playing_d;
            game_over_q <= game_over_d;
            won_q       <= won_d;
        end
    end

    assign regen      = regen_q;
    assign row_idx    = row_idx_q;
    assign round      = round_q;
    assign score      = score_q;
    assign misses     = misses_q;
    assign hit_pulse  = hit_q;
    assign miss_pulse = miss_q;
    assign playing    = playing_q;
    assign game_over  = game_over_q;
    assign won        = won_q;

endmodule

// File: tb/tb_tile_game_sequencer.sv
// Scoreboard bench for tile_game_sequencer: expected pulse events are queued by the stimulus
// and matched by a negedge monitor; level outputs are checked directly at key points.
module tb_tile_game_sequencer;
    import tile_game_pkg::*;

    logic        clk = 1'b0;
    logic        Reset = 1'b1;
    logic        start_btn = 1'b0;
    logic        frame_tick = 1'b0;
    logic        key_valid = 1'b0;
    logic [2:0]  key_lane = 3'b000;
    logic [2:0]  cur_note = NOTE_M;
    logic        regen;
    logic [6:0]  row_idx;
    logic [2:0]  round;
    logic [15:0] score;
    logic [1:0]  misses;
    logic        hit_pulse, miss_pulse, playing, game_over, won;

    tile_game_sequencer dut (
        .clk       (clk),
        .Reset     (Reset),
        .start_btn (start_btn),
        .frame_tick(frame_tick),
        .key_valid (key_valid),
        .key_lane  (key_lane),
        .cur_note  (cur_note),
        .regen     (regen),
        .row_idx   (row_idx),
        .round     (round),
        .score     (score),
        .misses    (misses),
        .hit_pulse (hit_pulse),
        .miss_pulse(miss_pulse),
        .playing   (playing),
        .game_over (game_over),
        .won       (won)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  kind;   // 0 regen, 1 hit, 2 miss
        logic [15:0] score;
        logic [1:0]  misses;
        logic [6:0]  row;
        logic [2:0]  round;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  e_score, e_miss, e_row, e_round;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void push(input int kind);
        ev_t e;
        e.kind   = 2'(kind);
        e.score  = 16'(e_score);
        e.misses = 2'(e_miss);
        e.row    = 7'(e_row);
        e.round  = 3'(e_round);
        exp_q.push_back(e);
    endfunction

    function automatic void exp_hit();
        e_score++;
        if (e_row < 99) e_row++;
        push(1);
    endfunction

    function automatic void exp_miss();
        e_miss++;
        if (e_row < 99) e_row++;
        push(2);
    endfunction

    // Monitor: every pulse must match the next queued expectation.
    ev_t        mon_e;
    logic [1:0] mon_kind;
    always @(negedge clk) begin
        if (regen === 1'b1 || hit_pulse === 1'b1 || miss_pulse === 1'b1) begin
            mon_kind = regen ? 2'd0 : (hit_pulse ? 2'd1 : 2'd2);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: got kind %0d expected none", mon_kind);
            end else begin
                mon_e = exp_q.pop_front();
                chk("ev_kind", 64'(mon_kind), 64'(mon_e.kind));
                if (mon_kind == 2'd0)
                    chk("ev_regen_state", {round, score, misses},
                        {mon_e.round, mon_e.score, mon_e.misses});
                else
                    chk("ev_state", {round, score, misses, row_idx},
                        {mon_e.round, mon_e.score, mon_e.misses, mon_e.row});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [2:0] lane, input logic [2:0] note, input logic tick);
        key_valid  = 1'b1;
        key_lane   = lane;
        cur_note   = note;
        frame_tick = tick;
        step();
        key_valid  = 1'b0;
        frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            step();
        end
    endtask

    // Rising edge on start_btn, then wait (bounded) for playing; reports edges and regen cycles.
    task automatic start_game(output int n, output int rg);
        start_btn = 1'b0;
        step();
        start_btn = 1'b1;
        n  = 0;
        rg = 0;
        while (!playing && n < 20) begin
            step();
            n++;
            if (regen) rg++;
        end
    endtask

    logic [2:0] notes [3];
    int n, rg;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        notes[0] = NOTE_L;
        notes[1] = NOTE_M;
        notes[2] = NOTE_R;

        // 1: reset with start held high; releasing reset must not yield an edge.
        start_btn = 1'b1;
        repeat (3) step();
        chk("reset_outputs", {regen, row_idx, round, score, misses, hit_pulse, miss_pulse,
                              playing, game_over, won}, 64'd0);
        Reset = 1'b0;
        rg = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (regen) rg++;
        end
        chk("no_regen_held", 64'(rg), 64'd0);
        chk("idle_round", 64'(round), 64'd0);

        // 2: start -> single regen pulse, PLAY after LOAD_CYCLES+1 edges.
        e_round = 1; e_score = 0; e_miss = 0; e_row = 0;
        push(0);
        start_game(n, rg);
        chk("load_latency", 64'(n), 64'd3);
        chk("regen_width", 64'(rg), 64'd1);
        chk("play_row0", 64'(row_idx), 64'd0);
        chk("play_round1", 64'(round), 64'd1);

        // 3: hit then wrong-lane miss.
        exp_hit();
        press(NOTE_M, NOTE_M, 1'b0);
        exp_miss();
        press(NOTE_L, NOTE_M, 1'b0);

        // 4: timeout on the 60th tick; a correct key on a timeout tick is a pure hit.
        ticks(59);
        chk("no_early_timeout", 64'(misses), 64'd1);
        exp_miss();
        ticks(1);
        ticks(59);
        exp_hit();
        press(NOTE_M, NOTE_M, 1'b1);
        step();
        chk("key_beats_timeout", 64'(misses), 64'd2);

        // 5: third miss ends the game; keys are then ignored; start restarts.
        exp_miss();
        press(NOTE_R, NOTE_M, 1'b0);
        step();
        chk("lose_game_over", 64'(game_over), 64'd1);
        chk("lose_won", 64'(won), 64'd0);
        chk("lose_not_playing", 64'(playing), 64'd0);
        for (int i = 0; i < 3; i++) press(NOTE_M, NOTE_M, 1'b0);
        step();
        chk("over_score_held", 64'(score), 64'd2);
        e_round = 1; e_score = 0; e_miss = 0; e_row = 0;
        push(0);
        start_game(n, rg);
        chk("restart_round", 64'(round), 64'd1);
        chk("restart_score", 64'(score), 64'd0);

        // 6: four clean rounds of 100 rows.
        for (int r = 1; r <= 4; r++) begin
            for (int i = 0; i < 100; i++) begin
                exp_hit();
                press(notes[i % 3], notes[i % 3], 1'b0);
            end
            if (r < 4) begin
                step();
                chk("round_done_row_held", 64'(row_idx), 64'd99);
                chk("round_done_not_playing", 64'(playing), 64'd0);
                e_round = r + 1;
                e_row   = 0;
                push(0);
                start_game(n, rg);
                chk("next_round_row0", 64'(row_idx), 64'd0);
            end
        end
        repeat (3) step();
        chk("win_game_over", 64'(game_over), 64'd1);
        chk("win_won", 64'(won), 64'd1);
        chk("win_score", 64'(score), 64'd400);
        chk("win_round", 64'(round), 64'd4);

        // Reset while playing.
        e_round = 1; e_score = 0; e_miss = 0; e_row = 0;
        push(0);
        start_game(n, rg);
        exp_hit();
        press(NOTE_L, NOTE_L, 1'b0);
        @(negedge clk);
        Reset = 1'b1;
        step();
        chk("midplay_reset", {regen, row_idx, round, score, misses, hit_pulse, miss_pulse,
                              playing, game_over, won}, 64'd0);
        Reset = 1'b0;
        step();
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
